// File: rtl/sha3_iterable_pkg.sv
// Shared types for the iterable SHA3 round loop.
package sha3_iterable_pkg;
    localparam int ROUNDS_DEFAULT = 24;

    typedef logic [63:0] lane_t;
    typedef lane_t [4:0] plane_t;   // five lanes, index 0 = lane a
    typedef plane_t [4:0] state_t;  // five planes, index 0 = plane a

    typedef enum logic {FLUSH, RUN} fsm_t;
endpackage

// File: rtl/sha3_state_reg.sv
// 25-lane state register with load enable and a per-cycle valid strobe.
module sha3_state_reg
    import sha3_iterable_pkg::*;
(
    input  logic   clk,
    input  logic   rstn,
    input  logic   load,
    input  logic   vld_in,
    input  state_t d,
    output state_t q,
    output logic   vld
);

    // Valid follows its input every cycle; data only moves on load and holds otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q   <= '0;
            vld <= 1'b0;
        end else begin
            vld <= vld_in;
            if (load) q <= d;
        end
    end

endmodule

// File: rtl/sha3_iterable_round_loop_ctrl.sv
// Round loop closure: recirculates states through the round halves, emits
// finished permutations, injects new states into free slots, and flushes
// the un-reset round pipeline after reset.
module sha3_iterable_round_loop_ctrl
    import sha3_iterable_pkg::*;
#(
    parameter int ROUNDS       = ROUNDS_DEFAULT,
    parameter int LOOP_LATENCY = 4,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  plane_t     isa, isb, isc, isd, ise,
    input  logic       isample,
    output logic       oready,
    input  plane_t     fsa, fsb, fsc, fsd, fse,
    input  logic [4:0] fround,
    input  logic       fgood,
    output plane_t     rsa, rsb, rsc, rsd, rse,
    output logic [4:0] rround,
    output logic       rgood,
    output plane_t     osa, osb, osc, osd, ose,
    output logic       ogood,
    output logic [2:0] oinflight,
    output logic       oerror
);

    localparam int CW = $clog2(LOOP_LATENCY + 1);
    localparam logic [4:0] LAST = 5'(ROUNDS - 1);

    fsm_t          state_q, state_n;
    logic [CW-1:0] flush_cnt, flush_cnt_n;
    logic          run;

    state_t in_st, fb_st, rs_st, os_st, rec_d;
    logic   cont, fin, ill, acc, rec_ld;

    assign in_st = {ise, isd, isc, isb, isa};
    assign fb_st = {fse, fsd, fsc, fsb, fsa};

    // FSM state and flush counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= FLUSH;
            flush_cnt <= CW'(LOOP_LATENCY);
        end else begin
            state_q   <= state_n;
            flush_cnt <= flush_cnt_n;
        end
    end

    // Leave FLUSH on the cycle the counter hits zero.
    always_comb begin
        state_n     = state_q;
        flush_cnt_n = flush_cnt;
        if (state_q == FLUSH) begin
            flush_cnt_n = flush_cnt - CW'(1);
            if (flush_cnt == CW'(1)) state_n = RUN;
        end
    end

    // Feedback is only honoured once the stale pipeline contents are gone.
    always_comb begin
        run = (state_q == RUN);
    end

    assign cont = run && fgood && (fround <  LAST);
    assign fin  = run && fgood && (fround == LAST);
    assign ill  = run && fgood && (fround >  LAST);

    // A continuing state owns the slot; otherwise a slot is free if below the
    // in-flight cap or a hash is leaving this very cycle.
    assign oready = run && !cont && ((oinflight < 3'(MAX_INFLIGHT)) || fin || ill);
    assign acc    = isample && oready;

    assign rec_ld = cont || acc;
    assign rec_d  = cont ? fb_st : in_st;

    sha3_state_reg u_rec (
        .clk(clk), .rstn(rstn), .load(rec_ld), .vld_in(rec_ld),
        .d(rec_d), .q(rs_st), .vld(rgood)
    );

    sha3_state_reg u_res (
        .clk(clk), .rstn(rstn), .load(fin), .vld_in(fin),
        .d(fb_st), .q(os_st), .vld(ogood)
    );

    // Round index for the first half; fround+1 cannot wrap since fround <= ROUNDS-2.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)     rround <= '0;
        else if (cont) rround <= fround + 5'd1;
        else if (acc)  rround <= '0;
    end

    // In-flight count and sticky illegal-round flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            oinflight <= '0;
            oerror    <= 1'b0;
        end else begin
            oinflight <= oinflight + 3'(acc) - 3'(fin || ill);
            if (ill) oerror <= 1'b1;
        end
    end

    assign {rse, rsd, rsc, rsb, rsa} = rs_st;
    assign {ose, osd, osc, osb, osa} = os_st;

endmodule

// File: tb/tb_sha3_iterable_round_loop_ctrl.sv
// Directed bench for the SHA3 round loop controller.
module tb_sha3_iterable_round_loop_ctrl;
    import sha3_iterable_pkg::*;

    localparam int LL = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    plane_t     isa, isb, isc, isd, ise;
    logic       isample = 1'b0;
    logic       oready;
    plane_t     fsa, fsb, fsc, fsd, fse;
    logic [4:0] fround;
    logic       fgood;
    plane_t     rsa, rsb, rsc, rsd, rse;
    logic [4:0] rround;
    logic       rgood;
    plane_t     osa, osb, osc, osd, ose;
    logic       ogood;
    logic [2:0] oinflight;
    logic       oerror;

    int n_cmp = 0;
    int n_bad = 0;

    // manual feedback drive vs. echo loop model
    logic       echo_en = 1'b0;
    logic       m_fgood = 1'b0;
    logic [4:0] m_fround = '0;
    state_t     m_fs = '0;
    state_t     in_st = '0;

    logic       pg [LL];
    logic [4:0] pr [LL];
    state_t     ps [LL];
    state_t     rs_st, fs_st;

    always #5 clk = ~clk;

    assign {ise, isd, isc, isb, isa} = in_st;
    assign rs_st = {rse, rsd, rsc, rsb, rsa};
    assign fs_st = echo_en ? ps[LL-1] : m_fs;
    assign {fse, fsd, fsc, fsb, fsa} = fs_st;
    assign fgood  = echo_en ? pg[LL-1] : m_fgood;
    assign fround = echo_en ? pr[LL-1] : m_fround;

    // Loop model: identity round pipeline with LL cycles from rgood to fgood.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LL; i++) begin
                pg[i] <= 1'b0; pr[i] <= '0; ps[i] <= '0;
            end
        end else begin
            pg[0] <= rgood; pr[0] <= rround; ps[0] <= rs_st;
            for (int i = 1; i < LL; i++) begin
                pg[i] <= pg[i-1]; pr[i] <= pr[i-1]; ps[i] <= ps[i-1];
            end
        end
    end

    sha3_iterable_round_loop_ctrl #(
        .ROUNDS(24), .LOOP_LATENCY(LL), .MAX_INFLIGHT(4)
    ) dut (
        .clk(clk), .rstn(rstn),
        .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
        .isample(isample), .oready(oready),
        .fsa(fsa), .fsb(fsb), .fsc(fsc), .fsd(fsd), .fse(fse),
        .fround(fround), .fgood(fgood),
        .rsa(rsa), .rsb(rsb), .rsc(rsc), .rsd(rsd), .rse(rse),
        .rround(rround), .rgood(rgood),
        .osa(osa), .osb(osb), .osc(osc), .osd(osd), .ose(ose),
        .ogood(ogood), .oinflight(oinflight), .oerror(oerror)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        smp;  logic [63:0] is0;
        logic        fg;   logic [4:0]  fr;   logic [63:0] fs0;
        logic        rdy;
        logic        rg;   logic [4:0]  rr;   logic [63:0] rs0;
        logic        og;   logic [63:0] os0;
        logic [2:0]  inf;  logic        err;
    } vec_t;

    function automatic vec_t mk(input logic smp, input logic [63:0] is0,
                                input logic fg, input logic [4:0] fr, input logic [63:0] fs0,
                                input logic rdy, input logic rg, input logic [4:0] rr,
                                input logic [63:0] rs0, input logic og, input logic [63:0] os0,
                                input logic [2:0] inf, input logic err);
        vec_t v;
        v.smp = smp; v.is0 = is0; v.fg = fg; v.fr = fr; v.fs0 = fs0; v.rdy = rdy;
        v.rg = rg; v.rr = rr; v.rs0 = rs0; v.og = og; v.os0 = os0; v.inf = inf; v.err = err;
        return v;
    endfunction

    vec_t tbl [14];

    initial begin
        int exp_r, ocnt, ocyc, order_bad;

        // starts with inflight=0, os held at 1 from the full hash
        tbl[0]  = mk(1, 64'h55, 1,  7, 64'hAA, 0, 1, 8, 64'hAA, 0, 64'h1,  0, 0);
        tbl[1]  = mk(1, 64'h55, 0,  0, 64'h0,  1, 1, 0, 64'h55, 0, 64'h1,  1, 0);
        tbl[2]  = mk(1, 64'h66, 1, 23, 64'h77, 1, 1, 0, 64'h66, 1, 64'h77, 1, 0);
        tbl[3]  = mk(0, 64'h0,  0,  0, 64'h0,  1, 0, 0, 64'h0,  0, 64'h77, 1, 0);
        tbl[4]  = mk(1, 64'hA1, 0,  0, 64'h0,  1, 1, 0, 64'hA1, 0, 64'h77, 2, 0);
        tbl[5]  = mk(1, 64'hA2, 0,  0, 64'h0,  1, 1, 0, 64'hA2, 0, 64'h77, 3, 0);
        tbl[6]  = mk(1, 64'hA3, 0,  0, 64'h0,  1, 1, 0, 64'hA3, 0, 64'h77, 4, 0);
        tbl[7]  = mk(1, 64'hA4, 0,  0, 64'h0,  0, 0, 0, 64'h0,  0, 64'h77, 4, 0);
        tbl[8]  = mk(1, 64'hA4, 0,  0, 64'h0,  0, 0, 0, 64'h0,  0, 64'h77, 4, 0);
        tbl[9]  = mk(1, 64'hA4, 1, 23, 64'h88, 1, 1, 0, 64'hA4, 1, 64'h88, 4, 0);
        tbl[10] = mk(0, 64'h0,  1, 25, 64'h99, 1, 0, 0, 64'h0,  0, 64'h88, 3, 1);
        tbl[11] = mk(0, 64'h0,  0,  0, 64'h0,  1, 0, 0, 64'h0,  0, 64'h88, 3, 1);
        tbl[12] = mk(0, 64'h0,  1, 30, 64'h0,  1, 0, 0, 64'h0,  0, 64'h88, 2, 1);
        tbl[13] = mk(1, 64'hB1, 1,  5, 64'hCC, 0, 1, 6, 64'hCC, 0, 64'h88, 2, 1);

        // reset values, with stale feedback present
        m_fgood = 1'b1; m_fround = 5'd0;
        #2;
        chk("rst_rgood", rgood, 0);     chk("rst_ogood", ogood, 0);
        chk("rst_oerror", oerror, 0);   chk("rst_inflight", oinflight, 0);
        chk("rst_rround", rround, 0);   chk("rst_rsa", rsa[0], 0);
        chk("rst_osa", osa[0], 0);      chk("rst_oready", oready, 0);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        #1 chk("flush_rdy0", oready, 0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 3) m_fgood = 1'b0;
            #1;
            chk($sformatf("flush_rdy%0d", k), oready, (k >= 4));
            chk($sformatf("flush_rgood%0d", k), rgood, 0);
            chk($sformatf("flush_ogood%0d", k), ogood, 0);
        end

        // one full hash through the echo loop
        echo_en = 1'b1;
        in_st = '0; in_st[0][0] = 64'h1; isample = 1'b1;
        #1 chk("hash_rdy", oready, 1);
        @(negedge clk);
        isample = 1'b0; in_st = '0;
        exp_r = 0; ocnt = 0; ocyc = 0; order_bad = 0;
        for (int c = 1; c <= 130; c++) begin
            if (rgood) begin
                if (rround != 5'(exp_r)) order_bad++;
                exp_r++;
            end
            if (ogood) begin ocnt++; ocyc = c; end
            if (c == 1) chk("hash_inflight1", oinflight, 1);
            @(negedge clk);
        end
        chk("hash_round_order", order_bad, 0);
        chk("hash_rounds", exp_r, 24);
        chk("hash_ogood_cnt", ocnt, 1);
        chk("hash_ogood_cycle", ocyc, 121);
        chk("hash_result", osa[0], 64'h1);
        chk("hash_inflight0", oinflight, 0);
        echo_en = 1'b0;

        // corner-case vectors: retry, finish+accept, cap, illegal rounds
        foreach (tbl[i]) begin
            isample = tbl[i].smp; in_st = '0; in_st[0][0] = tbl[i].is0;
            m_fgood = tbl[i].fg; m_fround = tbl[i].fr; m_fs = '0; m_fs[0][0] = tbl[i].fs0;
            #1 chk($sformatf("v%0d_oready", i), oready, tbl[i].rdy);
            @(negedge clk);
            chk($sformatf("v%0d_rgood", i), rgood, tbl[i].rg);
            if (tbl[i].rg) begin
                chk($sformatf("v%0d_rround", i), rround, tbl[i].rr);
                chk($sformatf("v%0d_rsa", i), rsa[0], tbl[i].rs0);
            end
            chk($sformatf("v%0d_ogood", i), ogood, tbl[i].og);
            chk($sformatf("v%0d_osa", i), osa[0], tbl[i].os0);
            chk($sformatf("v%0d_inflight", i), oinflight, tbl[i].inf);
            chk($sformatf("v%0d_oerror", i), oerror, tbl[i].err);
        end
        isample = 1'b0; m_fgood = 1'b0;

        // asynchronous reset mid-operation
        #2 rstn = 1'b0;
        #1;
        chk("arst_inflight", oinflight, 0); chk("arst_oerror", oerror, 0);
        chk("arst_rgood", rgood, 0);        chk("arst_osa", osa[0], 0);
        chk("arst_oready", oready, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
